// File: rtl/alu_operand_fetch.sv
// Operand fetch stage: reads little-endian source/destination words from byte memory and hands them to the ALU.
// Optional build macro ALU_FETCH_SAME_ADDR_EN: skip the destination reads when src and dst addresses match.
module alu_operand_fetch #(
    parameter int AW = 16
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic          byte_mode,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic [15:0]   src_op,
    output logic [15:0]   dst_op,
    output logic          op_byte,
    output logic          op_valid,
    input  logic          op_ready,
    output logic          busy,
    output logic [2:0]    state_dbg
);

    // Handshake: operands transfer on a rising edge where op_valid && op_ready are both high;
    // op_valid, src_op, dst_op and op_byte stay stable until that edge.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_SL = 3'd1,
        RD_SH = 3'd2,
        RD_DL = 3'd3,
        RD_DH = 3'd4,
        LAST  = 3'd5,
        VALID = 3'd6
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] next_addr;
    logic          next_rd;
    logic          same_addr;

`ifdef ALU_FETCH_SAME_ADDR_EN
    assign same_addr = (src_q == dst_q);
`else
    assign same_addr = 1'b0;
`endif

    assign state_dbg = state;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_rd    = 1'b0;
        next_addr  = mem_addr;
        case (state)
            IDLE:    if (start) next_state = RD_SL;
            RD_SL:   next_state = (op_byte && !same_addr) ? RD_DL : RD_SH;
            RD_SH:   next_state = same_addr ? LAST : RD_DL;
            RD_DL:   next_state = RD_DH;
            RD_DH:   next_state = LAST;
            LAST:    next_state = VALID;
            VALID:   if (op_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Address/strobe are registered for the state being entered, so they line up with it.
        case (next_state)
            RD_SL: begin
                next_rd   = 1'b1;
                next_addr = src_addr;
            end
            RD_SH: begin
                next_rd   = 1'b1;
                next_addr = src_q + ADDR_ONE;
            end
            RD_DL: begin
                next_rd   = 1'b1;
                next_addr = dst_q;
            end
            RD_DH: begin
                next_rd   = 1'b1;
                next_addr = dst_q + ADDR_ONE;
            end
            default: begin
                next_rd   = 1'b0;
                next_addr = mem_addr;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            op_byte  <= 1'b0;
            src_op   <= '0;
            dst_op   <= '0;
        end else begin
            mem_rd   <= next_rd;
            mem_addr <= next_addr;
            op_valid <= (next_state == VALID);
            busy     <= (next_state != IDLE);
            // mem_rdata in each state carries the byte requested in the previous state.
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        op_byte <= byte_mode;
                    end
                end
                RD_SH: begin
                    src_op[7:0] <= mem_rdata;
                    if (same_addr) dst_op[7:0] <= mem_rdata;
                end
                RD_DL: begin
                    if (op_byte) src_op <= {8'h00, mem_rdata};
                    else         src_op[15:8] <= mem_rdata;
                end
                RD_DH: dst_op[7:0] <= mem_rdata;
                LAST: begin
                    dst_op[15:8] <= mem_rdata;
                    if (same_addr) src_op[15:8] <= op_byte ? 8'h00 : mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: table-driven fetches, read-address scoreboard, stall/wrap/reset cases.
module tb_alu_operand_fetch;

    logic        Clock;
    logic        Reset_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic        byte_mode;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [15:0] src_op;
    logic [15:0] dst_op;
    logic        op_byte;
    logic        op_valid;
    logic        op_ready;
    logic        busy;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr_q[$];
    logic [32:0] exp_op_q[$];

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic        bm;
        logic [15:0] exp_src;
        logic [15:0] exp_dst;
        int          stall;
        logic        start_at_hs;
    } vec_t;

    vec_t vecs[$];

    alu_operand_fetch #(.AW(16)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .byte_mode (byte_mode),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .src_op    (src_op),
        .dst_op    (dst_op),
        .op_byte   (op_byte),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One-cycle-latency byte memory.
    always @(posedge Clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every read strobe must match the next expected address.
    always @(negedge Clock) begin
        if (Reset_n && mem_rd) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_read", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("read_addr", {16'h0, mem_addr}, {16'h0, exp_addr_q.pop_front()});
            end
        end
    end

    function automatic logic is_same(input logic [15:0] s, input logic [15:0] d);
`ifdef ALU_FETCH_SAME_ADDR_EN
        return (s == d);
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_fetch(input vec_t v);
        logic        same;
        int          lat;
        int          exp_lat;
        logic [32:0] e;
        same = is_same(v.src, v.dst);
        exp_addr_q.push_back(v.src);
        if (!v.bm || same) exp_addr_q.push_back(v.src + 16'd1);
        if (!same) begin
            exp_addr_q.push_back(v.dst);
            exp_addr_q.push_back(v.dst + 16'd1);
        end
        exp_lat = same ? 3 : (v.bm ? 4 : 5);
        exp_op_q.push_back({v.bm, v.exp_src, v.exp_dst});

        @(negedge Clock);
        start     = 1'b1;
        src_addr  = v.src;
        dst_addr  = v.dst;
        byte_mode = v.bm;
        @(negedge Clock);
        start     = 1'b0;
        src_addr  = $urandom_range(0, 65535);
        dst_addr  = $urandom_range(0, 65535);
        byte_mode = 1'($urandom_range(0, 1));
        lat = 0;
        while (!op_valid && lat < 20) begin
            op_ready = 1'($urandom_range(0, 1));
            @(negedge Clock);
            lat++;
        end
        op_ready = 1'b0;
        if (!op_valid) begin
            chk("valid_timeout", 32'(lat), 32'(exp_lat));
            return;
        end
        chk("valid_latency", 32'(lat), 32'(exp_lat));
        chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
        chk("busy_in_valid", {31'h0, busy}, 32'd1);
        e = exp_op_q.pop_front();
        chk("src_op", {16'h0, src_op}, {16'h0, e[31:16]});
        chk("dst_op", {16'h0, dst_op}, {16'h0, e[15:0]});
        chk("op_byte", {31'h0, op_byte}, {31'h0, e[32]});

        for (int i = 0; i < v.stall; i++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge Clock);
            chk("stall_valid", {31'h0, op_valid}, 32'd1);
            chk("stall_src", {16'h0, src_op}, {16'h0, e[31:16]});
            chk("stall_dst", {16'h0, dst_op}, {16'h0, e[15:0]});
        end
        op_ready = 1'b1;
        start    = v.start_at_hs;
        @(negedge Clock);
        op_ready = 1'b0;
        start    = 1'b0;
        chk("hs_valid_low", {31'h0, op_valid}, 32'd0);
        chk("hs_idle", {29'h0, state_dbg}, 32'd0);
        if (v.start_at_hs) begin
            @(negedge Clock);
            chk("hs_start_ignored", {31'h0, busy}, 32'd0);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] s, input logic [15:0] d, input logic bm,
                                input logic [15:0] es, input logic [15:0] ed,
                                input int st, input logic sh);
        vec_t v;
        v.src = s; v.dst = d; v.bm = bm; v.exp_src = es; v.exp_dst = ed;
        v.stall = st; v.start_at_hs = sh;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [15:0] s;
        logic [15:0] d;
        logic        bm;
        int          wait_n;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(0, 255));
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        mem[16'h0012] = 8'hCD; mem[16'h0013] = 8'hAB;
        mem[16'h0014] = 8'h5A;
        mem[16'hFFFF] = 8'h7F; mem[16'h0000] = 8'h80;
        mem[16'h0020] = 8'h01; mem[16'h0021] = 8'h80;

        vecs.push_back(mk(16'h0010, 16'h0012, 1'b0, 16'h1234, 16'hABCD, 2, 1'b0));
        vecs.push_back(mk(16'h0011, 16'h0012, 1'b1, 16'h0012, 16'hABCD, 0, 1'b0));
        vecs.push_back(mk(16'hFFFF, 16'h0012, 1'b0, 16'h807F, 16'hABCD, 10, 1'b1));
        vecs.push_back(mk(16'h0020, 16'h0020, 1'b0, 16'h8001, 16'h8001, 1, 1'b0));
        vecs.push_back(mk(16'h0020, 16'h0020, 1'b1, 16'h0001, 16'h8001, 0, 1'b0));
        vecs.push_back(mk(16'h0012, 16'hFFFF, 1'b1, 16'h00CD, 16'h807F, 3, 1'b1));
        vecs.push_back(mk(16'h0013, 16'h0010, 1'b0, 16'h5AAB, 16'h1234, 0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            s  = 16'($urandom_range(16'h0100, 16'hFF00));
            d  = (i == 2) ? s : 16'($urandom_range(16'h0100, 16'hFF00));
            bm = 1'($urandom_range(0, 1));
            vecs.push_back(mk(s, d, bm,
                              bm ? {8'h00, mem[s]} : {mem[s + 16'd1], mem[s]},
                              {mem[d + 16'd1], mem[d]},
                              $urandom_range(0, 3), 1'($urandom_range(0, 1))));
        end

        Reset_n = 1'b0; start = 1'b0; op_ready = 1'b0;
        src_addr = '0; dst_addr = '0; byte_mode = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_valid", {31'h0, op_valid}, 32'd0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        chk("rst_ops", {src_op, dst_op}, 32'd0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_fetch(vecs[i]);

        // Asynchronous reset in the middle of a fetch.
        exp_addr_q.push_back(16'h0010); exp_addr_q.push_back(16'h0011);
        exp_addr_q.push_back(16'h0012); exp_addr_q.push_back(16'h0013);
        @(negedge Clock);
        start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h0012; byte_mode = 1'b0;
        @(negedge Clock);
        start = 1'b0;
        wait_n = 0;
        while (state_dbg != 3'd3 && wait_n < 10) begin
            @(negedge Clock);
            wait_n++;
        end
        chk("reach_rd_dl", {29'h0, state_dbg}, 32'd3);
        #2 Reset_n = 1'b0;
        #1;
        chk("amid_mem_rd", {31'h0, mem_rd}, 32'd0);
        chk("amid_busy", {31'h0, busy}, 32'd0);
        chk("amid_ops", {src_op, dst_op}, 32'd0);
        chk("amid_state", {29'h0, state_dbg}, 32'd0);
        exp_addr_q.delete();
        @(negedge Clock);
        Reset_n = 1'b1;
        run_fetch(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Upstream stage of the ALU. On a start pulse it reads the source and destination operands from the byte-wide, little-endian data memory: two byte reads per word, with a one-cycle read latency. It assembles the 16-bit operands and presents them, together with the byte/word flag, to the ALU through a valid/ready handshake. One operation is in flight at a time.

## Interface
Parameters:
- AW, 16, memory address width; operand addresses wrap modulo 2^AW.

Ports:
- Clock  in  1  single clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a fetch; sampled only in IDLE.
- src_addr  in  AW  byte address of source low byte; sampled with start.
- dst_addr  in  AW  byte address of destination low byte; sampled with start.
- byte_mode  in  1  1 = .b operation; sampled with start.
- mem_addr  out  AW  memory read address.
- mem_rd  out  1  read strobe; data returns on mem_rdata one cycle later.
- mem_rdata  in  8  read data, valid in the cycle after the mem_rd cycle.
- src_op  out  16  assembled source operand.
- dst_op  out  16  assembled destination operand.
- op_byte  out  1  latched byte_mode.
- op_valid  out  1  operands valid for the ALU.
- op_ready  in  1  ALU accepts operands.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RD_SL, RD_SH, RD_DL, RD_DH, LAST, VALID.
- IDLE: mem_rd=0. When start=1, latch the addresses and byte_mode, then go to RD_SL.
- RD_SL: issue src_addr. Next state is RD_SH (word) or RD_DL (byte).
- RD_SH: issue src_addr+1; capture src_op[7:0]. Next state is RD_DL.
- RD_DL: issue dst_addr; capture the previous byte (src_op[15:8] in word mode, src_op[7:0] in byte mode). Next state is RD_DH.
- RD_DH: issue dst_addr+1; capture dst_op[7:0]. Next state is LAST.
- LAST: mem_rd=0; capture dst_op[15:8]. Next state is VALID.
- VALID: op_valid=1. src_op, dst_op and op_byte are held stable. When op_ready=1 on an edge, go to IDLE.
- Byte mode: src_op[15:8] is forced to 0. The destination is always read as a full word, because the ALU passes dst[15:8] through on .b operations.
- Address increment wraps: a base address of 16'hFFFF reads its high byte from 16'h0000.
- mem_addr holds its last value when mem_rd=0.
- start outside IDLE is ignored and is not queued. This includes the edge on which a VALID handshake completes.
- op_ready outside VALID is ignored.

Reset (asynchronous, any state, including mid-fetch):
- State goes to IDLE.
- mem_rd=0, op_valid=0, busy=0.
- src_op=0, dst_op=0, op_byte=0, mem_addr=0.

## Timing
- E0 = the edge that samples start in IDLE.
- Word mode: mem_rd is high in the 4 cycles after E0; op_valid rises after E0+5.
- Byte mode: mem_rd is high in 3 cycles; op_valid rises after E0+4.
- Back-to-back throughput: the next start is accepted no earlier than the first IDLE cycle after the handshake. The minimum word period is 7 cycles.
- Outputs are registered. There is no combinational path from op_ready or start to any output.

## Configuration
- ALU_FETCH_SAME_ADDR_EN defined:
  - If the latched src_addr equals dst_addr, the RD_DL and RD_DH states are skipped. Path: RD_SL, RD_SH, LAST.
  - In this path the state that would otherwise be RD_SH captures the low byte, and LAST captures the high byte.
  - dst_op is loaded with the full word. src_op is loaded with the same word in word mode, or {8'h00, low byte} in byte mode.
  - op_valid rises after E0+3 in both modes.
- ALU_FETCH_SAME_ADDR_EN undefined: addresses are never compared; every fetch uses the full sequence above.

## Test plan
- Word fetch: memory[0x10..0x13] = 34 12 CD AB; start with src=0x10, dst=0x12, byte_mode=0. Required: mem_addr sequence 10, 11, 12, 13; src_op=0x1234, dst_op=0xABCD; op_valid rises after E0+5.
- Byte fetch: same memory; src=0x11, dst=0x12, byte_mode=1. Required: reads 11, 12, 13 only; src_op=0x0012, dst_op=0xABCD, op_byte=1; op_valid after E0+4.
- Wrap and stall: src=0xFFFF, with memory[0xFFFF]=0x7F and memory[0x0000]=0x80. Required: src_op=0x807F. Hold op_ready=0 for 10 cycles: op_valid and the operands stay stable. Pulse op_ready=1 together with start=1: returns to IDLE and that start is ignored.
- Reset mid-fetch: assert Reset_n=0 asynchronously in RD_DL. Required: immediately mem_rd=0, busy=0, src_op=0, dst_op=0. After release, a new word fetch completes normally.
- Same address: src=dst=0x20, memory[0x20..0x21] = 01 80, word mode.
  - With ALU_FETCH_SAME_ADDR_EN: two reads; src_op=dst_op=0x8001; op_valid after E0+3.
  - Without it: four reads; same operand values; op_valid after E0+5.
